comp_gain_sched: RTL and testbench
==================================

Name: comp_gain_sched

Overview:
- Multi-channel gain scheduler for the compressor path.
- Accepts audio samples from NCH channels and keeps one attack/hold/release gain state machine per channel.
- Time-shares a single external gains multiplier (16-bit sample × 6-bit fractional gain, fixed pipeline latency) among the channels using round-robin arbitration.
- Sits between the audio source (I2S receiver per channel) and the effects chain; replaces per-channel compressor instances.

Parameters:
- NCH, 2, number of audio channels (2..4).
- MUL_LAT, 1, gains multiplier latency in clk cycles from mul_valid to mul_result valid (1..4).
- ATTACK_STEPS, 10, samples of gain reduction after the last over-threshold sample.
- RELEASE_HOLD, 50, below-threshold samples in HOLD before release starts.
- GAIN_MIN, 8, floor of the 6-bit gain code.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  1 = compress, 0 = bypass
- thre_para  in  3  threshold select: threshold = 5000 + 1000*thre_para (5000..12000)
- in_valid  in  NCH  per-channel sample strobe
- in_ready  out  NCH  per-channel input buffer empty
- in_data  in  16*NCH  signed samples, channel k at bits [16k+15:16k]
- mul_valid  out  1  issue strobe to multiplier
- mul_data  out  16  signed sample to multiplier
- mul_gain  out  6  gain code to multiplier (63 = max)
- mul_result  in  16  signed multiplier result, valid MUL_LAT cycles after mul_valid
- out_valid  out  NCH  one-cycle result strobe per channel
- out_data  out  16*NCH  signed result per channel, held until that channel's next out_valid
- busy  out  1  any buffer full or any result in flight

Behaviour:
- Reset values: out_valid=0, out_data=0, mul_valid=0, mul_data=0, mul_gain=63, busy=0.
- State after reset: all buffers empty (in_ready all 1), all channels IDLE with gain=63 and counters 0, round-robin pointer at channel 0.
- Reset mid-operation discards buffered samples and in-flight results; no out_valid is produced for them.
- Input capture:
  - Each channel has a 1-entry buffer; it captures on in_valid & in_ready.
  - in_ready = buffer empty (combinational from a register). It drops the cycle after capture and rises the cycle after that channel is issued.
- Arbitration and issue:
  - At most one issue per cycle. The issued channel is the first full buffer at or after the pointer.
  - On issue: mul_valid=1, mul_data=sample, mul_gain=that channel's current gain (before update). The buffer frees and the pointer moves to grant+1 mod NCH.
  - The multiplier accepts every cycle, so there is no backpressure.
  - A channel-id/bypass/raw-sample shift register of depth MUL_LAT tracks each issue.
  - Output: out_valid[id] pulses exactly MUL_LAT cycles after issue, and out_data[id] = mul_result (or the raw sample if bypass).
- Level calculation:
  - level = |sample|, with -32768 saturating to 32767.
  - "over" = level > threshold; thre_para is sampled at issue.
  - The FSM updates only when its own channel issues.
- Per-channel FSM:
  - IDLE: gain=63. If over: go to ATTACK, cnt=ATTACK_STEPS.
  - ATTACK: gain <= max(gain - (gain>>1), GAIN_MIN). If over: cnt reloads to ATTACK_STEPS; else cnt decrements. When cnt reaches 0: go to HOLD with hcnt=0.
  - HOLD: gain unchanged. If over: go to ATTACK (reload cnt). Else hcnt+1; hcnt==RELEASE_HOLD-1 goes to RELEASE.
  - RELEASE: if over: go to ATTACK. Else gain+1; the update that reaches 63 goes to IDLE.
- Bypass (en=0 at issue):
  - Sample flagged bypass; mul_valid still asserts with gain 63 (keeps latency uniform).
  - out_data = raw sample; channel FSM forced to IDLE with gain=63.
- Simultaneous events:
  - Capture and issue cannot target the same channel in one cycle.
  - Two channels' results can never coincide; one issue per cycle guarantees this.

Test Plan:
- Reset, en=1, thre_para=0, ch0 sends 1000 → mul_gain=63, out_valid[0] exactly MUL_LAT cycles after mul_valid, out_data[0]=mul_result, ch1 out_valid stays 0.
- Both channels present samples every cycle (in_valid=2'b11) → issues alternate ch0,ch1,ch0…; in_ready toggles; no sample lost or duplicated (scoreboard over 100 samples).
- ch0 sends 20000 once, then 100s, thre_para=0:
  - mul_gain sequence 63,32,16,8,8,… for ATTACK_STEPS samples, then 8 for 50 HOLD samples.
  - Then 9,10,…,63, then IDLE.
  - ch1 stays at 63 throughout.
- ch0 sends -32768 with thre_para=7 → counted as over (level 32767), ATTACK entered; 11000 with thre_para=7 → not over, stays IDLE.
- en=0 mid-ATTACK → out_data = raw in_data, next issue has gain 63 and FSM IDLE; en=1 again with 3000 → gain 63, no attack.
- Assert reset while MUL_LAT results are in flight → all outputs return to reset values immediately; no out_valid after release; first new sample uses gain 63.

Source files
------------

// File: rtl/comp_gain_sched.sv
// Multi-channel compressor gain scheduler: one attack/hold/release gain FSM per channel,
// sharing a single external sample x gain multiplier through round-robin issue.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | no compression, gain held at 63
// ST_ATTACK  | gain halves toward the floor each sample, cnt counts down
// ST_HOLD    | gain frozen, hcnt counts below-threshold samples
// ST_RELEASE | gain climbs by one code per sample back to 63
module comp_gain_sched #(
  parameter int NCH          = 2,
  parameter int MUL_LAT      = 1,
  parameter int ATTACK_STEPS = 10,
  parameter int RELEASE_HOLD = 50,
  parameter int GAIN_MIN     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic [2:0]         thre_para,
  input  logic [NCH-1:0]     in_valid,
  output logic [NCH-1:0]     in_ready,
  input  logic [16*NCH-1:0]  in_data,
  output logic               mul_valid,
  output logic [15:0]        mul_data,
  output logic [5:0]         mul_gain,
  input  logic [15:0]        mul_result,
  output logic [NCH-1:0]     out_valid,
  output logic [16*NCH-1:0]  out_data,
  output logic               busy
);

  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int CW = $clog2(ATTACK_STEPS + 1);
  localparam int HW = $clog2(RELEASE_HOLD + 1);

  localparam logic [5:0]    GAIN_MAX   = 6'd63;
  localparam logic [5:0]    GAIN_FLOOR = 6'(GAIN_MIN);
  localparam logic [CW-1:0] CNT_LOAD   = CW'(ATTACK_STEPS);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(RELEASE_HOLD - 1);
  localparam logic [IW-1:0] LAST_CH    = IW'(NCH - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ATTACK  = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } gain_state_t;

  logic [NCH-1:0] buf_full;
  logic [15:0]    buf_data [NCH];
  logic [IW-1:0]  rr_ptr;

  logic           grant_v;
  logic [IW-1:0]  grant_id;
  logic [IW-1:0]  arb_cand;
  int             arb_idx;

  gain_state_t    ch_state [NCH];
  logic [5:0]     ch_gain  [NCH];
  logic [CW-1:0]  ch_cnt   [NCH];
  logic [HW-1:0]  ch_hcnt  [NCH];

  logic [15:0]    iss_sample;
  logic [15:0]    level;
  logic [15:0]    threshold;
  logic           over;

  gain_state_t    cur_st, nxt_st;
  logic [5:0]     cur_gain, nxt_gain, half_gain, atk_gain;
  logic [CW-1:0]  cur_cnt, nxt_cnt;
  logic [HW-1:0]  cur_hcnt, nxt_hcnt;

  logic [IW-1:0]  mul_id;
  logic           mul_byp;

  logic [MUL_LAT-1:0] pipe_v;
  logic [MUL_LAT-1:0] pipe_byp;
  logic [IW-1:0]      pipe_id  [MUL_LAT];
  logic [15:0]        pipe_raw [MUL_LAT];

  logic               tail_v;
  logic               tail_byp;
  logic [IW-1:0]      tail_id;
  logic [15:0]        tail_res;
  logic [15:0]        out_hold [NCH];

  // Input buffers: a full buffer is never captured into, so capture and issue never collide.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_full <= '0;
      for (int k = 0; k < NCH; k++) buf_data[k] <= '0;
    end else begin
      for (int k = 0; k < NCH; k++) begin
        if (grant_v && grant_id == IW'(k)) begin
          buf_full[k] <= 1'b0;
        end else if (in_valid[k] && !buf_full[k]) begin
          buf_full[k] <= 1'b1;
          buf_data[k] <= in_data[16*k +: 16];
        end
      end
    end
  end

  assign in_ready = ~buf_full;

  always_comb begin
    grant_v  = 1'b0;
    grant_id = '0;
    arb_idx  = 0;
    arb_cand = '0;
    for (int off = 0; off < NCH; off++) begin
      arb_idx  = (int'(rr_ptr) + off) % NCH;
      arb_cand = IW'(arb_idx);
      if (!grant_v && buf_full[arb_cand]) begin
        grant_v  = 1'b1;
        grant_id = arb_cand;
      end
    end
  end

  assign iss_sample = buf_data[grant_id];

  // -32768 has no positive twin in 16 bits, so it saturates to full scale.
  always_comb begin
    if (iss_sample == 16'h8000)  level = 16'h7fff;
    else if (iss_sample[15])     level = -iss_sample;
    else                         level = iss_sample;
    threshold = 16'd5000 + 16'd1000 * {13'd0, thre_para};
    over      = (level > threshold);
  end

  always_comb begin
    cur_st    = ch_state[grant_id];
    cur_gain  = ch_gain[grant_id];
    cur_cnt   = ch_cnt[grant_id];
    cur_hcnt  = ch_hcnt[grant_id];
    nxt_st    = cur_st;
    nxt_gain  = cur_gain;
    nxt_cnt   = cur_cnt;
    nxt_hcnt  = cur_hcnt;
    half_gain = cur_gain - (cur_gain >> 1);
    atk_gain  = (half_gain < GAIN_FLOOR) ? GAIN_FLOOR : half_gain;
    if (!en) begin
      nxt_st   = ST_IDLE;
      nxt_gain = GAIN_MAX;
      nxt_cnt  = '0;
      nxt_hcnt = '0;
    end else begin
      case (cur_st)
        ST_IDLE: begin
          nxt_gain = GAIN_MAX;
          if (over) begin
            nxt_st   = ST_ATTACK;
            nxt_gain = atk_gain;
            nxt_cnt  = CNT_LOAD;
          end
        end
        ST_ATTACK: begin
          nxt_gain = atk_gain;
          if (over) begin
            nxt_cnt = CNT_LOAD;
          end else if (cur_cnt <= CW'(1)) begin
            nxt_st   = ST_HOLD;
            nxt_cnt  = '0;
            nxt_hcnt = '0;
          end else begin
            nxt_cnt = cur_cnt - 1'b1;
          end
        end
        ST_HOLD: begin
          if (over) begin
            nxt_st   = ST_ATTACK;
            nxt_cnt  = CNT_LOAD;
            nxt_hcnt = '0;
          end else if (cur_hcnt == HOLD_LAST) begin
            nxt_st   = ST_RELEASE;
            nxt_hcnt = '0;
          end else begin
            nxt_hcnt = cur_hcnt + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (over) begin
            nxt_st  = ST_ATTACK;
            nxt_cnt = CNT_LOAD;
          end else begin
            nxt_gain = cur_gain + 6'd1;
            if (cur_gain == GAIN_MAX - 6'd1) nxt_st = ST_IDLE;
          end
        end
        default: begin
          nxt_st   = ST_IDLE;
          nxt_gain = GAIN_MAX;
          nxt_cnt  = '0;
          nxt_hcnt = '0;
        end
      endcase
    end
  end

  // Channel FSMs advance only on their own issue; the issued gain is the pre-update value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) begin
        ch_state[k] <= ST_IDLE;
        ch_gain[k]  <= GAIN_MAX;
        ch_cnt[k]   <= '0;
        ch_hcnt[k]  <= '0;
      end
      rr_ptr    <= '0;
      mul_valid <= 1'b0;
      mul_data  <= '0;
      mul_gain  <= GAIN_MAX;
      mul_id    <= '0;
      mul_byp   <= 1'b0;
    end else begin
      mul_valid <= grant_v;
      if (grant_v) begin
        ch_state[grant_id] <= nxt_st;
        ch_gain[grant_id]  <= nxt_gain;
        ch_cnt[grant_id]   <= nxt_cnt;
        ch_hcnt[grant_id]  <= nxt_hcnt;
        rr_ptr             <= (grant_id == LAST_CH) ? '0 : grant_id + 1'b1;
        mul_data           <= iss_sample;
        mul_gain           <= en ? cur_gain : GAIN_MAX;
        mul_id             <= grant_id;
        mul_byp            <= !en;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pipe_v   <= '0;
      pipe_byp <= '0;
      for (int i = 0; i < MUL_LAT; i++) begin
        pipe_id[i]  <= '0;
        pipe_raw[i] <= '0;
      end
    end else begin
      pipe_v[0]   <= mul_valid;
      pipe_byp[0] <= mul_byp;
      pipe_id[0]  <= mul_id;
      pipe_raw[0] <= mul_data;
      for (int i = 1; i < MUL_LAT; i++) begin
        pipe_v[i]   <= pipe_v[i-1];
        pipe_byp[i] <= pipe_byp[i-1];
        pipe_id[i]  <= pipe_id[i-1];
        pipe_raw[i] <= pipe_raw[i-1];
      end
    end
  end

  // The tail stage lines up with mul_result, so the result is forwarded in its valid cycle.
  assign tail_v   = pipe_v[MUL_LAT-1];
  assign tail_byp = pipe_byp[MUL_LAT-1];
  assign tail_id  = pipe_id[MUL_LAT-1];
  assign tail_res = tail_byp ? pipe_raw[MUL_LAT-1] : mul_result;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NCH; k++) out_hold[k] <= '0;
    end else if (tail_v) begin
      out_hold[tail_id] <= tail_res;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < NCH; k++) begin
      out_valid[k]        = tail_v && (tail_id == IW'(k));
      out_data[16*k +: 16] = out_valid[k] ? tail_res : out_hold[k];
    end
  end

  assign busy = (|buf_full) | mul_valid | (|pipe_v);

endmodule

// File: tb/tb_comp_gain_sched.sv
// Directed bench for comp_gain_sched with a behavioural fixed-latency multiplier.
module tb_comp_gain_sched;
  localparam int NCH     = 2;
  localparam int MUL_LAT = 1;

  logic                 clk;
  logic                 reset;
  logic                 en;
  logic [2:0]           thre_para;
  logic [NCH-1:0]       in_valid;
  logic [NCH-1:0]       in_ready;
  logic [16*NCH-1:0]    in_data;
  logic                 mul_valid;
  logic [15:0]          mul_data;
  logic [5:0]           mul_gain;
  logic [15:0]          mul_result;
  logic [NCH-1:0]       out_valid;
  logic [16*NCH-1:0]    out_data;
  logic                 busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  comp_gain_sched #(
    .NCH(NCH), .MUL_LAT(MUL_LAT), .ATTACK_STEPS(10), .RELEASE_HOLD(50), .GAIN_MIN(8)
  ) dut (
    .clk(clk), .reset(reset), .en(en), .thre_para(thre_para),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mul_valid(mul_valid), .mul_data(mul_data), .mul_gain(mul_gain),
    .mul_result(mul_result), .out_valid(out_valid), .out_data(out_data), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic signed [15:0] mul_ref(input logic signed [15:0] d, input logic [5:0] g);
    int p;
    p = int'(d) * int'(g);
    return 16'(p >>> 6);
  endfunction

  logic signed [15:0] mpipe [MUL_LAT];
  always @(posedge clk) begin
    for (int i = MUL_LAT - 1; i > 0; i--) mpipe[i] <= mpipe[i-1];
    mpipe[0] <= mul_ref(mul_data, mul_gain);
  end
  assign mul_result = mpipe[MUL_LAT-1];

  // Expected issued gain for the n-th ch0 sample of the 20000-then-100s sequence.
  function automatic logic [5:0] exp_gain(input int i);
    if (i == 0)        return 6'd63;
    else if (i == 1)   return 6'd32;
    else if (i == 2)   return 6'd16;
    else if (i <= 60)  return 6'd8;
    else if (i <= 115) return 6'(8 + i - 61);
    else               return 6'd63;
  endfunction

  task automatic apply_reset();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic run_sample(input int ch, input logic signed [15:0] d, input logic en_v,
                            input logic [2:0] th, output logic [5:0] g,
                            output logic signed [15:0] od, output logic ov_early,
                            output logic [NCH-1:0] ov_all, output logic rdy_after,
                            output bit tmo);
    bit found;
    g = '0; od = '0; ov_early = 1'b0; ov_all = '0; rdy_after = 1'b1; tmo = 1'b0;
    found = 1'b0;
    @(negedge clk);
    en                  = en_v;
    thre_para           = th;
    in_data[16*ch +: 16] = d;
    in_valid[ch]        = 1'b1;
    @(posedge clk);
    #1 in_valid[ch] = 1'b0;
    @(negedge clk);
    rdy_after = in_ready[ch];
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (mul_valid) found = 1'b1;
    end
    if (!found) begin
      tmo = 1'b1;
      return;
    end
    g        = mul_gain;
    ov_early = out_valid[ch];
    repeat (MUL_LAT) @(negedge clk);
    ov_all = out_valid;
    od     = out_data[16*ch +: 16];
  endtask

  task automatic test_reset();
    reset = 1'b1; en = 1'b1; thre_para = 3'd0; in_valid = '0; in_data = '0;
    repeat (2) @(negedge clk);
    vec_cnt++; if (out_valid !== 2'b00) begin err_cnt++; $display("FAIL reset_out_valid: got %b expected 00", out_valid); end
    vec_cnt++; if (out_data !== 32'd0) begin err_cnt++; $display("FAIL reset_out_data: got %h expected 0", out_data); end
    vec_cnt++; if (mul_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_mul_valid: got %b expected 0", mul_valid); end
    vec_cnt++; if (mul_data !== 16'd0) begin err_cnt++; $display("FAIL reset_mul_data: got %h expected 0", mul_data); end
    vec_cnt++; if (mul_gain !== 6'd63) begin err_cnt++; $display("FAIL reset_mul_gain: got %0d expected 63", mul_gain); end
    vec_cnt++; if (busy !== 1'b0) begin err_cnt++; $display("FAIL reset_busy: got %b expected 0", busy); end
    vec_cnt++; if (in_ready !== 2'b11) begin err_cnt++; $display("FAIL reset_in_ready: got %b expected 11", in_ready); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    logic [5:0] g; logic signed [15:0] od; logic ove, rdy; logic [NCH-1:0] ova; bit tmo;
    run_sample(0, 16'sd1000, 1'b1, 3'd0, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo) begin err_cnt++; $display("FAIL basic_issue: no mul_valid within bound"); end
    vec_cnt++; if (rdy !== 1'b0) begin err_cnt++; $display("FAIL basic_ready_drop: got %b expected 0", rdy); end
    vec_cnt++; if (g !== 6'd63) begin err_cnt++; $display("FAIL basic_gain: got %0d expected 63", g); end
    vec_cnt++; if (ove !== 1'b0) begin err_cnt++; $display("FAIL basic_early_valid: got %b expected 0", ove); end
    vec_cnt++; if (ova !== 2'b01) begin err_cnt++; $display("FAIL basic_out_valid: got %b expected 01", ova); end
    vec_cnt++; if (od !== 16'sd984) begin err_cnt++; $display("FAIL basic_out_data: got %0d expected 984", od); end
    @(negedge clk);
    vec_cnt++; if (out_valid !== 2'b00) begin err_cnt++; $display("FAIL basic_pulse_width: got %b expected 00", out_valid); end
    vec_cnt++; if ($signed(out_data[15:0]) !== 16'sd984) begin err_cnt++; $display("FAIL basic_hold: got %0d expected 984", $signed(out_data[15:0])); end
    vec_cnt++; if (in_ready !== 2'b11) begin err_cnt++; $display("FAIL basic_ready_back: got %b expected 11", in_ready); end
  endtask

  task automatic test_back_to_back();
    logic signed [15:0] q0[$];
    logic signed [15:0] q1[$];
    logic signed [15:0] e;
    int cap [2];
    int outs, prev, id;
    bit have, done;
    cap[0] = 0; cap[1] = 0; outs = 0; prev = -1; done = 1'b0;
    en = 1'b1; thre_para = 3'd0;
    for (int cyc = 0; cyc < 400 && !done; cyc++) begin
      @(negedge clk);
      if (mul_valid) begin
        id = ($signed(mul_data) >= 2000) ? 1 : 0;
        if (prev >= 0) begin
          vec_cnt++;
          if (id == prev) begin err_cnt++; $display("FAIL b2b_alternate: channel %0d issued twice in a row", id); end
        end
        prev = id;
      end
      for (int k = 0; k < NCH; k++) begin
        if (out_valid[k]) begin
          have = 1'b0; e = '0;
          if (k == 0 && q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
          if (k == 1 && q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
          vec_cnt++;
          if (!have || $signed(out_data[16*k +: 16]) !== mul_ref(e, 6'd63)) begin
            err_cnt++;
            $display("FAIL b2b_data ch%0d: got %0d expected %0d (queued=%0d)", k, $signed(out_data[16*k +: 16]), mul_ref(e, 6'd63), have);
          end
          outs++;
        end
      end
      for (int k = 0; k < NCH; k++) begin
        if (cap[k] < 50) begin
          in_valid[k]         = 1'b1;
          in_data[16*k +: 16] = 16'((k == 0 ? 100 : 2000) + cap[k]);
          if (in_ready[k]) begin
            if (k == 0) q0.push_back(16'(100 + cap[k]));
            else        q1.push_back(16'(2000 + cap[k]));
            cap[k]++;
          end
        end else begin
          in_valid[k] = 1'b0;
        end
      end
      if (cap[0] == 50 && cap[1] == 50 && q0.size() == 0 && q1.size() == 0 && !busy) done = 1'b1;
    end
    in_valid = '0;
    vec_cnt++;
    if (!done || outs != 100) begin err_cnt++; $display("FAIL b2b_count: got %0d results expected 100 (drained=%0d)", outs, done); end
  endtask

  task automatic test_gain_sched();
    logic [5:0] g; logic signed [15:0] od, d; logic ove, rdy; logic [NCH-1:0] ova; bit tmo;
    apply_reset();
    for (int i = 0; i < 120; i++) begin
      d = (i == 0) ? 16'sd20000 : 16'sd100;
      run_sample(0, d, 1'b1, 3'd0, g, od, ove, ova, rdy, tmo);
      vec_cnt++;
      if (tmo || g !== exp_gain(i)) begin err_cnt++; $display("FAIL sched_gain[%0d]: got %0d expected %0d (timeout=%0d)", i, g, exp_gain(i), tmo); end
      vec_cnt++;
      if (od !== mul_ref(d, exp_gain(i))) begin err_cnt++; $display("FAIL sched_data[%0d]: got %0d expected %0d", i, od, mul_ref(d, exp_gain(i))); end
      if (i == 5 || i == 80 || i == 119) begin
        run_sample(1, 16'sd100, 1'b1, 3'd0, g, od, ove, ova, rdy, tmo);
        vec_cnt++;
        if (tmo || g !== 6'd63) begin err_cnt++; $display("FAIL sched_ch1_gain at %0d: got %0d expected 63", i, g); end
      end
    end
  endtask

  task automatic test_threshold();
    logic [5:0] g; logic signed [15:0] od; logic ove, rdy; logic [NCH-1:0] ova; bit tmo;
    apply_reset();
    run_sample(0, -16'sd32768, 1'b1, 3'd7, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd63) begin err_cnt++; $display("FAIL thr_neg_gain: got %0d expected 63", g); end
    vec_cnt++; if (od !== -16'sd32256) begin err_cnt++; $display("FAIL thr_neg_data: got %0d expected -32256", od); end
    run_sample(0, 16'sd100, 1'b1, 3'd7, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd32) begin err_cnt++; $display("FAIL thr_neg_attack: got %0d expected 32", g); end
    apply_reset();
    run_sample(0, 16'sd11000, 1'b1, 3'd7, g, od, ove, ova, rdy, tmo);
    run_sample(0, 16'sd12000, 1'b1, 3'd7, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd63) begin err_cnt++; $display("FAIL thr_11000_idle: got %0d expected 63", g); end
    run_sample(0, 16'sd100, 1'b1, 3'd7, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd63) begin err_cnt++; $display("FAIL thr_12000_idle: got %0d expected 63", g); end
    run_sample(0, 16'sd12001, 1'b1, 3'd7, g, od, ove, ova, rdy, tmo);
    run_sample(0, 16'sd100, 1'b1, 3'd7, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd32) begin err_cnt++; $display("FAIL thr_12001_attack: got %0d expected 32", g); end
  endtask

  task automatic test_bypass();
    logic [5:0] g; logic signed [15:0] od; logic ove, rdy; logic [NCH-1:0] ova; bit tmo;
    apply_reset();
    run_sample(0, 16'sd20000, 1'b1, 3'd0, g, od, ove, ova, rdy, tmo);
    run_sample(0, 16'sd100, 1'b1, 3'd0, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd32) begin err_cnt++; $display("FAIL byp_pre_attack: got %0d expected 32", g); end
    run_sample(0, 16'sd5555, 1'b0, 3'd0, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd63) begin err_cnt++; $display("FAIL byp_gain: got %0d expected 63", g); end
    vec_cnt++; if (od !== 16'sd5555) begin err_cnt++; $display("FAIL byp_raw: got %0d expected 5555", od); end
    vec_cnt++; if (ova !== 2'b01) begin err_cnt++; $display("FAIL byp_valid: got %b expected 01", ova); end
    run_sample(0, -16'sd7, 1'b0, 3'd0, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (od !== -16'sd7) begin err_cnt++; $display("FAIL byp_raw_neg: got %0d expected -7", od); end
    run_sample(0, 16'sd3000, 1'b1, 3'd0, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd63) begin err_cnt++; $display("FAIL byp_resume_gain: got %0d expected 63", g); end
    vec_cnt++; if (od !== 16'sd2953) begin err_cnt++; $display("FAIL byp_resume_data: got %0d expected 2953", od); end
    run_sample(0, 16'sd3000, 1'b1, 3'd0, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd63) begin err_cnt++; $display("FAIL byp_no_attack: got %0d expected 63", g); end
  endtask

  task automatic test_reset_midflight();
    logic [5:0] g; logic signed [15:0] od; logic ove, rdy; logic [NCH-1:0] ova; bit tmo, found, seen;
    apply_reset();
    run_sample(0, 16'sd20000, 1'b1, 3'd0, g, od, ove, ova, rdy, tmo);
    found = 1'b0; seen = 1'b0;
    @(negedge clk);
    in_valid = 2'b11;
    in_data  = {16'sd200, 16'sd100};
    @(posedge clk);
    #1 in_valid = '0;
    for (int i = 0; i < 8 && !found; i++) begin
      @(negedge clk);
      if (mul_valid) found = 1'b1;
    end
    vec_cnt++; if (!found) begin err_cnt++; $display("FAIL rst_mid_issue: no mul_valid within bound"); end
    #1 reset = 1'b1;
    #1;
    vec_cnt++; if (out_valid !== 2'b00 || mul_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_valids: out_valid=%b mul_valid=%b expected 00/0", out_valid, mul_valid); end
    vec_cnt++; if (mul_gain !== 6'd63 || mul_data !== 16'd0) begin err_cnt++; $display("FAIL rst_mid_mul: gain=%0d data=%h expected 63/0", mul_gain, mul_data); end
    vec_cnt++; if (out_data !== 32'd0 || busy !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_out: data=%h busy=%b expected 0/0", out_data, busy); end
    vec_cnt++; if (in_ready !== 2'b11) begin err_cnt++; $display("FAIL rst_mid_ready: got %b expected 11", in_ready); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid !== 2'b00) seen = 1'b1;
    end
    vec_cnt++; if (seen) begin err_cnt++; $display("FAIL rst_mid_ghost: out_valid seen after reset, expected none"); end
    run_sample(0, 16'sd100, 1'b1, 3'd0, g, od, ove, ova, rdy, tmo);
    vec_cnt++; if (tmo || g !== 6'd63) begin err_cnt++; $display("FAIL rst_mid_first_gain: got %0d expected 63", g); end
    vec_cnt++; if (od !== 16'sd98) begin err_cnt++; $display("FAIL rst_mid_first_data: got %0d expected 98", od); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_gain_sched();
    test_threshold();
    test_bypass();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
